intr_controller: RTL and testbench

Memory-mapped interrupt controller that sits directly downstream of the timer and the other I/O devices. It collects their level-sensitive `intr` outputs, applies per-source masking and fixed priority, and raises a single request to the CPU with a source id. Software claims the request with `irq_ack` and retires it by writing the EOI register. Register access uses the same `abus`/`dbus`/`we` bus as the devices.

---
 rtl/intr_controller_if.sv | 22 ++
 rtl/intr_controller.sv | 136 +++++++++++++
 tb/tb_intr_controller.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intr_controller_if.sv
// CPU-side bundle of the interrupt controller: register bus controls
// plus the irq request/claim handshake.
interface intr_controller_if #(
    parameter int DBITS = 32,
    parameter int IDW   = 2
);
    logic [DBITS-1:0] abus;
    logic             we;
    logic             irq;
    logic             irq_ack;
    logic [IDW-1:0]   irq_id;

    modport master (
        output abus, we, irq_ack,
        input  irq, irq_id
    );

    modport slave (
        input  abus, we, irq_ack,
        output irq, irq_id
    );
endinterface

// File: rtl/intr_controller.sv
// Level-sensitive interrupt controller: pending/mask registers,
// fixed lowest-index priority and a request/claim/EOI handshake.
module intr_controller #(
    parameter int               DBITS     = 32,
    parameter int               NSRC      = 4,
    parameter int               IDW       = 2,
    parameter logic [DBITS-1:0] PEND_ADDR = 32'hF000_0200,
    parameter logic [DBITS-1:0] MASK_ADDR = 32'hF000_0204,
    parameter logic [DBITS-1:0] IID_ADDR  = 32'hF000_0208,
    parameter logic [DBITS-1:0] EOI_ADDR  = 32'hF000_020C
) (
    input  logic                clk,
    input  logic                init,
    intr_controller_if.slave    bus,
    inout  wire  [DBITS-1:0]    dbus,
    input  logic [NSRC-1:0]     src_intr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [NSRC-1:0]  pend;
    logic [NSRC-1:0]  maskEn;
    logic             gen;
    logic [NSRC-1:0]  elig;
    logic [IDW-1:0]   id;
    logic [IDW-1:0]   idNext;
    logic [IDW-1:0]   firstId;
    logic             pendSel;
    logic             maskSel;
    logic             iidSel;
    logic             maskWr;
    logic             eoiWr;
    logic             rdHit;
    logic [DBITS-1:0] rdData;

    assign pendSel = bus.abus == PEND_ADDR;
    assign maskSel = bus.abus == MASK_ADDR;
    assign iidSel  = bus.abus == IID_ADDR;
    assign maskWr  = bus.we && maskSel;
    assign eoiWr   = bus.we && (bus.abus == EOI_ADDR);

    assign elig = gen ? (pend & maskEn) : '0;

    // Sample the source levels and capture software mask writes.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            pend   <= '0;
            maskEn <= '0;
            gen    <= 1'b0;
        end else begin
            pend <= src_intr;
            if (maskWr) begin
                maskEn <= dbus[NSRC-1:0];
                gen    <= dbus[DBITS-1];
            end
        end
    end

    // Lowest eligible index wins.
    always_comb begin
        firstId = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) firstId = IDW'(i);
        end
    end

    // State and latched source id.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state <= IDLE;
            id    <= '0;
        end else begin
            state <= stateNext;
            id    <= idNext;
        end
    end

    // Request/claim/retire sequencing; ack beats withdrawal in REQ.
    always_comb begin
        stateNext = state;
        idNext    = id;
        unique case (state)
            IDLE: begin
                if (|elig) begin
                    stateNext = REQ;
                    idNext    = firstId;
                end
            end
            REQ: begin
                if (bus.irq_ack) stateNext = SERVICE;
                else if (!elig[id]) stateNext = IDLE;
            end
            SERVICE: begin
                if (eoiWr) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.irq    = state == REQ;
    assign bus.irq_id = id;

    // Combinational register read decode.
    always_comb begin
        rdHit  = 1'b0;
        rdData = '0;
        if (!bus.we) begin
            unique case (1'b1)
                pendSel: begin
                    rdHit            = 1'b1;
                    rdData[NSRC-1:0] = pend;
                end
                maskSel: begin
                    rdHit             = 1'b1;
                    rdData[NSRC-1:0]  = maskEn;
                    rdData[DBITS-1]   = gen;
                end
                iidSel: begin
                    rdHit            = 1'b1;
                    rdData[IDW-1:0]  = id;
                    rdData[DBITS-1]  = state == SERVICE;
                end
                default: ;
            endcase
        end
    end

    assign dbus = rdHit ? rdData : 'z;

endmodule

// File: tb/tb_intr_controller.sv
// Scoreboard bench for intr_controller: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_intr_controller;

    localparam logic [31:0] PEND_A = 32'hF000_0200;
    localparam logic [31:0] MASK_A = 32'hF000_0204;
    localparam logic [31:0] IID_A  = 32'hF000_0208;
    localparam logic [31:0] EOI_A  = 32'hF000_020C;
    localparam logic [31:0] NONE_A = 32'h0000_0000;
    localparam logic [31:0] ALL    = 32'hFFFF_FFFF;

    localparam int K_IRQ = 0;
    localparam int K_ID  = 1;
    localparam int K_BUS = 2;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        logic [31:0] msk;
    } exp_t;

    logic        clk;
    logic        init;
    logic [3:0]  srcIntr;
    logic        tbDrv;
    logic [31:0] tbData;
    wire  [31:0] dbus;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] act;
    int          tests;
    int          fails;

    intr_controller_if #(.DBITS(32), .IDW(2)) bus ();

    intr_controller dut (
        .clk      (clk),
        .init     (init),
        .bus      (bus),
        .dbus     (dbus),
        .src_intr (srcIntr)
    );

    assign dbus = tbDrv ? tbData : 'z;

    for (genvar i = 0; i < 32; i++) begin : g_pu
        pullup pu (dbus[i]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            cur = q.pop_front();
            case (cur.kind)
                K_IRQ:   act = {31'b0, bus.irq};
                K_ID:    act = {30'b0, bus.irq_id};
                default: act = dbus;
            endcase
            tests++;
            if ((act & cur.msk) !== (cur.exp & cur.msk)) begin
                fails++;
                $display("FAIL %s: got %h expected %h (mask %h)",
                         cur.name, act, cur.exp, cur.msk);
            end
        end
    end

    task automatic push(input string n, input int k,
                        input logic [31:0] e, input logic [31:0] m);
        exp_t x;
        x.name = n;
        x.kind = k;
        x.exp  = e;
        x.msk  = m;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expIrq(input string n, input logic i);
        push(n, K_IRQ, {31'b0, i}, ALL);
    endtask

    task automatic expReq(input string n, input logic i,
                          input logic [1:0] d);
        push({n, ".irq"}, K_IRQ, {31'b0, i}, ALL);
        push({n, ".id"}, K_ID, {30'b0, d}, ALL);
    endtask

    task automatic expRead(input string n, input logic [31:0] a,
                           input logic [31:0] e, input logic [31:0] m);
        bus.abus = a;
        bus.we   = 1'b0;
        push(n, K_BUS, e, m);
        @(negedge clk);
        #1;
        bus.abus = NONE_A;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        bus.abus = a;
        bus.we   = 1'b1;
        tbData   = d;
        tbDrv    = 1'b1;
        tick();
        bus.we   = 1'b0;
        tbDrv    = 1'b0;
        bus.abus = NONE_A;
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tests       = 0;
        fails       = 0;
        init        = 1'b1;
        srcIntr     = '0;
        tbDrv       = 1'b0;
        tbData      = '0;
        bus.abus    = NONE_A;
        bus.we      = 1'b0;
        bus.irq_ack = 1'b0;
        tick();
        tick();
        expReq("rst0", 1'b0, 2'd0);
        expRead("rst0.mask", MASK_A, 32'h0, ALL);
        init = 1'b0;
        tick();

        // Basic flow: two-edge request latency, ack, EOI
        busWrite(MASK_A, 32'h8000_0001);
        srcIntr = 4'b0001;
        tick();
        expIrq("lat.edgeN", 1'b0);
        tick();
        expReq("lat.edgeN1", 1'b1, 2'd0);
        expRead("mask.rd", MASK_A, 32'h8000_0001, ALL);
        ack();
        expReq("ack", 1'b0, 2'd0);
        expRead("iid.svc0", IID_A, 32'h8000_0000, ALL);
        busWrite(EOI_A, 32'h0);
        srcIntr = 4'b0000;
        expRead("iid.eoi", IID_A, 32'h0, ALL);
        tick();
        expReq("rereq", 1'b1, 2'd0);
        tick();
        expIrq("rereq.drop", 1'b0);

        // Priority and no preemption in REQ
        busWrite(MASK_A, 32'h8000_000F);
        srcIntr = 4'b1100;
        tick();
        tick();
        expReq("prio", 1'b1, 2'd2);
        ack();
        expReq("prio.ack", 1'b0, 2'd2);
        expRead("iid.svc2", IID_A, 32'h8000_0002, ALL);
        srcIntr = 4'b1000;
        busWrite(EOI_A, 32'hDEAD_BEEF);
        expIrq("eoi.gap", 1'b0);
        tick();
        expReq("next3", 1'b1, 2'd3);
        srcIntr = 4'b1001;
        tick();
        expReq("nopreempt.a", 1'b1, 2'd3);
        tick();
        expReq("nopreempt.b", 1'b1, 2'd3);
        ack();
        srcIntr = 4'b0000;
        busWrite(EOI_A, 32'h0);
        tick();
        expIrq("prio.idle", 1'b0);

        // Withdrawal, then ack racing the drop
        srcIntr = 4'b0010;
        tick();
        tick();
        expReq("wd.req", 1'b1, 2'd1);
        srcIntr = 4'b0000;
        tick();
        expIrq("wd.pend", 1'b1);
        tick();
        expIrq("wd.gone", 1'b0);
        srcIntr = 4'b0010;
        tick();
        tick();
        expReq("race.req", 1'b1, 2'd1);
        srcIntr = 4'b0000;
        tick();
        expIrq("race.pend", 1'b1);
        ack();
        expIrq("race.svc", 1'b0);
        expRead("race.iid", IID_A, 32'h8000_0001, ALL);
        busWrite(EOI_A, 32'h0);
        tick();
        expIrq("race.idle", 1'b0);

        // Masking: GEN off holds irq low; GEN on uses old mask at write edge
        busWrite(MASK_A, 32'h0000_000F);
        srcIntr = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            expIrq("gen0", 1'b0);
        end
        busWrite(MASK_A, 32'h8000_000F);
        expIrq("gen1.oldmask", 1'b0);
        tick();
        expReq("gen1.req", 1'b1, 2'd0);
        busWrite(MASK_A, 32'h8000_000E);
        expReq("mask.req.hold", 1'b1, 2'd0);
        tick();
        expIrq("mask.req.wd", 1'b0);
        tick();
        expReq("mask.next", 1'b1, 2'd1);
        busWrite(EOI_A, 32'h0);
        expReq("eoi.inreq", 1'b1, 2'd1);
        srcIntr = 4'b0000;
        busWrite(MASK_A, 32'h0);
        tick();
        tick();
        expIrq("mask.clean", 1'b0);

        // Bus behaviour
        busWrite(EOI_A, 32'h0);
        expIrq("eoi.idle", 1'b0);
        expRead("eoi.idle.iid", IID_A, 32'h0, 32'h8000_0000);
        srcIntr = 4'b1010;
        tick();
        expRead("pend.rd", PEND_A, 32'h0000_000A, ALL);
        expRead("unowned", 32'hF000_0020, ALL, ALL);
        expRead("eoi.noread", EOI_A, ALL, ALL);
        srcIntr = 4'b0000;
        tick();

        // Asynchronous reset in SERVICE with id 2
        busWrite(MASK_A, 32'h8000_000F);
        srcIntr = 4'b0100;
        tick();
        tick();
        expReq("r.req", 1'b1, 2'd2);
        ack();
        expRead("r.svc", IID_A, 32'h8000_0002, ALL);
        tick();
        #2;
        init = 1'b1;
        expReq("r.async", 1'b0, 2'd0);
        expRead("r.mask", MASK_A, 32'h0, ALL);
        expRead("r.iid", IID_A, 32'h0, ALL);
        expRead("r.pend", PEND_A, 32'h0, ALL);
        init    = 1'b0;
        srcIntr = 4'b0000;
        tick();

        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
